melody_sequencer: RTL and testbench

Control block that sequences the speaker datapath. It steps through a note table at a fixed tempo and drives the tone divider and mute inputs of the speaker/audio DAC path. A one-shot beep request preempts the melody for a fixed duration. The melody then resumes where it left off. It sits between the user-input debounce logic and the speaker module, and addresses an external combinational note ROM.

---
 rtl/melody_sequencer_if.sv | 27 ++
 rtl/melody_sequencer.sv | 162 ++++++++++++++++
 tb/tb_melody_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// Signal bundle between the melody sequencer, its user-input sources, the note ROM and the speaker path.
interface melody_sequencer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DIV_W  = 22
);
    logic              play;
    logic              stop;
    logic              repeat_en;
    logic              beep_req;
    logic [DIV_W-1:0]  beep_div;
    logic [ADDR_W-1:0] note_addr;
    logic [DIV_W-1:0]  rom_div;
    logic [DIV_W-1:0]  note_div;
    logic              mute;
    logic              playing;
    logic              beat_tick;

    modport master (
        output play, stop, repeat_en, beep_req, beep_div, rom_div,
        input  note_addr, note_div, mute, playing, beat_tick
    );

    modport slave (
        input  play, stop, repeat_en, beep_req, beep_div, rom_div,
        output note_addr, note_div, mute, playing, beat_tick
    );
endinterface

// File: rtl/melody_sequencer.sv
// Steps a note table at a fixed tempo and drives the speaker divider/mute;
// a one-shot beep preempts the melody, which then resumes where it left off.
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25000000,
    parameter int unsigned SONG_LEN    = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DIV_W       = 22,
    parameter int unsigned BEEP_CYCLES = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    melody_sequencer_if.slave bus
);
    localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, BEEP} state_t;

    state_t            state, state_nxt;
    state_t            ret_st, ret_st_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [BEEP_W-1:0] beep_cnt, beep_cnt_nxt;
    logic [DIV_W-1:0]  beep_latch, beep_latch_nxt;
    logic [ADDR_W-1:0] note_addr, note_addr_nxt;
    logic [DIV_W-1:0]  note_div, note_div_nxt;
    logic              mute, mute_nxt;
    logic              playing, playing_nxt;
    logic              beat_tick, beat_tick_nxt;

    logic beat_done_c;
    logic song_end_c;
    logic beep_done_c;

    assign beat_done_c = (beat_cnt == BEAT_LAST);
    assign song_end_c  = (note_addr == ADDR_LAST);
    assign beep_done_c = (beep_cnt == BEEP_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: stop beats beep_req, which beats play / end-of-song
    always_comb begin
        state_nxt = state;
        if (bus.stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.beep_req)  state_nxt = BEEP;
                    else if (bus.play) state_nxt = PLAY;
                end
                PLAY: begin
                    if (bus.beep_req)                                     state_nxt = BEEP;
                    else if (beat_done_c && song_end_c && !bus.repeat_en) state_nxt = IDLE;
                    else if (!bus.play)                                   state_nxt = PAUSE;
                end
                PAUSE: begin
                    if (bus.beep_req)  state_nxt = BEEP;
                    else if (bus.play) state_nxt = PLAY;
                end
                BEEP: begin
                    if (beep_done_c) state_nxt = ret_st;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters and next values of the registered outputs
    always_comb begin
        ret_st_nxt     = ret_st;
        beat_cnt_nxt   = beat_cnt;
        beep_cnt_nxt   = beep_cnt;
        beep_latch_nxt = beep_latch;
        note_addr_nxt  = note_addr;
        note_div_nxt   = note_div;
        mute_nxt       = mute;
        beat_tick_nxt  = 1'b0;
        playing_nxt    = (state_nxt == PLAY);

        if (bus.stop) begin
            note_addr_nxt = '0;
            beat_cnt_nxt  = '0;
            beep_cnt_nxt  = '0;
            mute_nxt      = 1'b1;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    mute_nxt = 1'b1;
                    if (state == IDLE) beat_cnt_nxt = '0;
                    if (bus.beep_req) begin
                        ret_st_nxt     = state;
                        beep_latch_nxt = bus.beep_div;
                        beep_cnt_nxt   = '0;
                    end
                end
                PLAY: begin
                    note_div_nxt = bus.rom_div;
                    mute_nxt     = (bus.rom_div == '0);
                    if (bus.beep_req) begin
                        ret_st_nxt     = PLAY;
                        beep_latch_nxt = bus.beep_div;
                        beep_cnt_nxt   = '0;
                    end else if (beat_done_c) begin
                        // A tick completes even if play drops on this cycle
                        beat_cnt_nxt  = '0;
                        beat_tick_nxt = 1'b1;
                        note_addr_nxt = song_end_c ? '0 : note_addr + ADDR_W'(1);
                    end else if (bus.play) begin
                        beat_cnt_nxt = beat_cnt + BEAT_W'(1);
                    end
                end
                BEEP: begin
                    note_div_nxt = beep_latch;
                    mute_nxt     = (beep_latch == '0);
                    beep_cnt_nxt = beep_done_c ? '0 : beep_cnt + BEEP_W'(1);
                end
                default: mute_nxt = 1'b1;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_st     <= IDLE;
            beat_cnt   <= '0;
            beep_cnt   <= '0;
            beep_latch <= '0;
            note_addr  <= '0;
            note_div   <= '0;
            mute       <= 1'b1;
            playing    <= 1'b0;
            beat_tick  <= 1'b0;
        end else begin
            ret_st     <= ret_st_nxt;
            beat_cnt   <= beat_cnt_nxt;
            beep_cnt   <= beep_cnt_nxt;
            beep_latch <= beep_latch_nxt;
            note_addr  <= note_addr_nxt;
            note_div   <= note_div_nxt;
            mute       <= mute_nxt;
            playing    <= playing_nxt;
            beat_tick  <= beat_tick_nxt;
        end
    end

    assign bus.note_addr = note_addr;
    assign bus.note_div  = note_div;
    assign bus.mute      = mute;
    assign bus.playing   = playing;
    assign bus.beat_tick = beat_tick;
endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: expected outputs are queued as stimulus is applied and compared after each edge.
module tb_melody_sequencer;
    localparam int unsigned BEAT_CYCLES = 4;
    localparam int unsigned SONG_LEN    = 4;
    localparam int unsigned ADDR_W      = 2;
    localparam int unsigned DIV_W       = 22;
    localparam int unsigned BEEP_CYCLES = 6;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DIV_W-1:0]  div;
        logic              mute;
        logic              playing;
        logic              tick;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    melody_sequencer_if #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) bus ();

    melody_sequencer #(
        .BEAT_CYCLES(BEAT_CYCLES),
        .SONG_LEN   (SONG_LEN),
        .ADDR_W     (ADDR_W),
        .DIV_W      (DIV_W),
        .BEEP_CYCLES(BEEP_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DIV_W-1:0] rom_val(input int n);
        case (n)
            0:       return DIV_W'(100);
            1:       return DIV_W'(200);
            2:       return DIV_W'(0);
            3:       return DIV_W'(400);
            default: return DIV_W'(0);
        endcase
    endfunction

    assign bus.rom_div = rom_val(int'(bus.note_addr));

    function automatic obs_t observe();
        obs_t o;
        o.addr    = bus.note_addr;
        o.div     = bus.note_div;
        o.mute    = bus.mute;
        o.playing = bus.playing;
        o.tick    = bus.beat_tick;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got addr/div/mute/playing/tick = 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push(input int addr, input int div, input bit mute, input bit playing, input bit tick);
        obs_t e;
        e.addr    = ADDR_W'(addr);
        e.div     = DIV_W'(div);
        e.mute    = mute;
        e.playing = playing;
        e.tick    = tick;
        exp_q.push_back(e);
    endtask

    task automatic sample(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 64'(observe()), {64{1'b1}});
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(observe()), 64'(e));
        end
    endtask

    // One clock: queue what the edge should produce, then compare #1 after it
    task automatic cyc(input string tag, input int addr, input int div,
                       input bit mute, input bit playing, input bit tick);
        push(addr, div, mute, playing, tick);
        @(posedge clk);
        #1;
        sample(tag);
    endtask

    task automatic now_chk(input string tag, input int addr, input int div,
                           input bit mute, input bit playing, input bit tick);
        push(addr, div, mute, playing, tick);
        sample(tag);
    endtask

    // k-th PLAY cycle counted from the first note of the song
    task automatic play_cyc(input string tag, input int k, input bit playing);
        int n;
        int c;
        n = (k / 4) % 4;
        c = k % 4;
        cyc($sformatf("%s%0d", tag, k), (c == 3) ? (n + 1) % 4 : n,
            int'(rom_val(n)), rom_val(n) == '0, playing, c == 3);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.play      = 1'b0;
        bus.stop      = 1'b0;
        bus.repeat_en = 1'b0;
        bus.beep_req  = 1'b0;
        bus.beep_div  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        now_chk("reset", 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Continuous play with wrap
        do_reset();
        bus.repeat_en = 1'b1;
        bus.play      = 1'b1;
        cyc("a_start", 0, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) play_cyc("a_play", k, 1'b1);

        // Single pass, stops at end of song
        do_reset();
        bus.play = 1'b1;
        cyc("b_start", 0, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) play_cyc("b_play", k, k != 15);
        bus.play = 1'b0;
        for (int i = 0; i < 4; i++) cyc($sformatf("b_idle%0d", i), 0, 400, 1'b1, 1'b0, 1'b0);

        // Pause at beat 2 of note 1, resume finishes the note in two cycles
        do_reset();
        bus.repeat_en = 1'b1;
        bus.play      = 1'b1;
        cyc("c_start", 0, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) play_cyc("c_play", k, 1'b1);
        bus.play = 1'b0;
        cyc("c_drop", 1, 200, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc($sformatf("c_pause%0d", i), 1, 200, 1'b1, 1'b0, 1'b0);
        bus.play = 1'b1;
        cyc("c_resume", 1, 200, 1'b1, 1'b1, 1'b0);
        cyc("c_beat2", 1, 200, 1'b0, 1'b1, 1'b0);
        cyc("c_beat3", 2, 200, 1'b0, 1'b1, 1'b1);
        cyc("c_note2", 2, 0, 1'b1, 1'b1, 1'b0);

        // Beep preempts note 1 at beat 1, second request ignored
        do_reset();
        bus.repeat_en = 1'b1;
        bus.play      = 1'b1;
        cyc("d_start", 0, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) play_cyc("d_play", k, 1'b1);
        bus.beep_req = 1'b1;
        bus.beep_div = DIV_W'(55);
        cyc("d_req", 1, 200, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            bus.beep_req = (j == 2);
            bus.beep_div = (j == 2) ? DIV_W'(99) : DIV_W'(0);
            cyc($sformatf("d_beep%0d", j), 1, 55, 1'b0, j == 5, 1'b0);
        end
        bus.beep_req = 1'b0;
        cyc("d_res1", 1, 200, 1'b0, 1'b1, 1'b0);
        cyc("d_res2", 1, 200, 1'b0, 1'b1, 1'b0);
        cyc("d_res3", 2, 200, 1'b0, 1'b1, 1'b1);
        cyc("d_note2", 2, 0, 1'b1, 1'b1, 1'b0);

        // Beep from IDLE returns to IDLE muted
        do_reset();
        bus.beep_req = 1'b1;
        bus.beep_div = DIV_W'(77);
        cyc("e_req", 0, 0, 1'b1, 1'b0, 1'b0);
        bus.beep_req = 1'b0;
        for (int j = 0; j < 6; j++) cyc($sformatf("e_beep%0d", j), 0, 77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc($sformatf("e_idle%0d", i), 0, 77, 1'b1, 1'b0, 1'b0);

        // Stop wins over a simultaneous beep request; stop cancels a running beep
        do_reset();
        bus.repeat_en = 1'b1;
        bus.play      = 1'b1;
        cyc("f_start", 0, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) play_cyc("f_play", k, 1'b1);
        bus.stop     = 1'b1;
        bus.beep_req = 1'b1;
        bus.beep_div = DIV_W'(55);
        cyc("f_stop", 0, 200, 1'b1, 1'b0, 1'b0);
        bus.stop     = 1'b0;
        bus.beep_req = 1'b0;
        bus.play     = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("f_idle%0d", i), 0, 200, 1'b1, 1'b0, 1'b0);
        bus.beep_req = 1'b1;
        cyc("f_req", 0, 200, 1'b1, 1'b0, 1'b0);
        bus.beep_req = 1'b0;
        cyc("f_beep0", 0, 55, 1'b0, 1'b0, 1'b0);
        cyc("f_beep1", 0, 55, 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b1;
        cyc("f_cancel", 0, 55, 1'b1, 1'b0, 1'b0);
        bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("f_after%0d", i), 0, 55, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-beep, between clock edges
        do_reset();
        bus.repeat_en = 1'b1;
        bus.play      = 1'b1;
        cyc("g_start", 0, 0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) play_cyc("g_play", k, 1'b1);
        bus.beep_req = 1'b1;
        bus.beep_div = DIV_W'(55);
        cyc("g_req", 1, 200, 1'b0, 1'b0, 1'b0);
        bus.beep_req = 1'b0;
        cyc("g_beep0", 1, 55, 1'b0, 1'b0, 1'b0);
        cyc("g_beep1", 1, 55, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        now_chk("g_async_rst", 0, 0, 1'b1, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        cyc("g_restart", 0, 0, 1'b1, 1'b1, 1'b0);
        play_cyc("g_replay", 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
